apb_master_bridge: RTL and testbench

//  APB3 initiator that turns a simple valid/ready request port (CPU/DMA side) into APB transfers.

---
 rtl/apb_master_bridge.sv | 191 +++++++++++++++++++
 tb/tb_apb_master_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_bridge.sv
`default_nettype none
// ============================================================================
// Module      : apb_master_bridge
// Description : APB3 initiator. Converts a valid/ready request port into APB
//               SETUP/ACCESS transfers on one of NUM_SLV slaves, waits on
//               PREADY (bounded by TIMEOUT) and returns read data or an error
//               on a one-cycle response strobe.
// Ports       : PCLK, PRESET            clock, async active-high reset
//               req_valid/req_ready     request handshake
//               req_write/addr/wdata    request direction, address, data
//               rsp_valid               one-cycle response strobe
//               rsp_rdata/rsp_err       response data and error (held)
//               PADDR/PWRITE/PWDATA     APB address, direction, write data
//               PENABLE/PSEL            APB access phase, one-hot select
//               PRDATA/PREADY           packed slave read data, per-slave ready
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master_bridge #(
   parameter int          NUM_SLV = 4,
   parameter logic [15:0] BASE_HI = 16'h1000,
   parameter int          TIMEOUT = 255
) (
   input  logic                    PCLK,
   input  logic                    PRESET,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [31:0]             req_addr,
   input  logic [31:0]             req_wdata,
   output logic                    rsp_valid,
   output logic [31:0]             rsp_rdata,
   output logic                    rsp_err,
   output logic [31:0]             PADDR,
   output logic                    PWRITE,
   output logic [31:0]             PWDATA,
   output logic                    PENABLE,
   output logic [NUM_SLV-1:0]      PSEL,
   input  logic [32*NUM_SLV-1:0]   PRDATA,
   input  logic [NUM_SLV-1:0]      PREADY
);

   localparam int          c_IDX_W   = $clog2(NUM_SLV);
   localparam logic [15:0] c_CNT_END = 16'(TIMEOUT - 1);
   localparam logic [NUM_SLV-1:0] c_SEL_ONE = {{(NUM_SLV-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;

   logic [31:0]          r_paddr;
   logic                 r_pwrite;
   logic [31:0]          r_pwdata;
   logic [c_IDX_W-1:0]   r_idx;
   logic [15:0]          r_cnt;
   logic [31:0]          r_rdata;
   logic                 r_err;

   logic                 w_hit;
   logic                 w_sel_ready;
   logic [31:0]          w_sel_rdata;
   logic                 w_timeout;
   logic                 w_bus_active;

   assign w_hit     = (req_addr[31:16] == BASE_HI);
   assign w_timeout = (r_cnt == c_CNT_END);

   // Only the latched slave's ready/data are looked at; the rest are ignored.
   always_comb begin
      w_sel_ready = 1'b0;
      w_sel_rdata = 32'd0;
      for (int i = 0; i < NUM_SLV; i++) begin
         if (int'(r_idx) == i) begin
            w_sel_ready = PREADY[i];
            w_sel_rdata = PRDATA[32*i +: 32];
         end
      end
   end

   // ------------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------------
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               // A decode miss skips the bus entirely and answers at once.
               w_state_nxt = w_hit ? ST_SETUP : ST_RESP;
            end
         end
         ST_SETUP: begin
            w_state_nxt = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (w_sel_ready || w_timeout) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath: request latch, wait counter, response registers
   // ------------------------------------------------------------------------
   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         r_paddr  <= 32'd0;
         r_pwrite <= 1'b0;
         r_pwdata <= 32'd0;
         r_idx    <= '0;
         r_cnt    <= 16'd0;
         r_rdata  <= 32'd0;
         r_err    <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  if (w_hit) begin
                     // Bus-facing registers only change for a real transfer,
                     // so PADDR/PWRITE/PWDATA keep their last value on a miss.
                     r_paddr  <= req_addr;
                     r_pwrite <= req_write;
                     r_pwdata <= req_wdata;
                     r_idx    <= req_addr[12 +: c_IDX_W];
                  end else begin
                     r_rdata <= 32'd0;
                     r_err   <= 1'b1;
                  end
               end
            end
            ST_SETUP: begin
               r_cnt <= 16'd0;
            end
            ST_ACCESS: begin
               if (w_sel_ready) begin
                  r_rdata <= r_pwrite ? 32'd0 : w_sel_rdata;
                  r_err   <= 1'b0;
               end else if (w_timeout) begin
                  // Counter value c_CNT_END marks the TIMEOUT-th ACCESS cycle.
                  r_rdata <= 32'd0;
                  r_err   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 16'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign w_bus_active = (r_state == ST_SETUP) || (r_state == ST_ACCESS);

   assign PSEL      = w_bus_active ? (c_SEL_ONE << r_idx) : '0;
   assign PENABLE   = (r_state == ST_ACCESS);
   assign PADDR     = r_paddr;
   assign PWRITE    = r_pwrite;
   assign PWDATA    = r_pwdata;
   assign rsp_valid = (r_state == ST_RESP);
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;
   assign req_ready = (r_state == ST_IDLE) && !PRESET;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_apb_master_bridge
// Description : Self-checking bench for apb_master_bridge with a behavioural
//               APB slave array and a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master_bridge;

   localparam int          NUM_SLV = 4;
   localparam logic [15:0] BASE_HI = 16'h1000;
   localparam int          TIMEOUT = 8;

   logic                  PCLK = 1'b0;
   logic                  PRESET = 1'b1;
   logic                  req_valid = 1'b0;
   logic                  req_ready;
   logic                  req_write = 1'b0;
   logic [31:0]           req_addr = 32'd0;
   logic [31:0]           req_wdata = 32'd0;
   logic                  rsp_valid;
   logic [31:0]           rsp_rdata;
   logic                  rsp_err;
   logic [31:0]           PADDR;
   logic                  PWRITE;
   logic [31:0]           PWDATA;
   logic                  PENABLE;
   logic [NUM_SLV-1:0]    PSEL;
   logic [32*NUM_SLV-1:0] PRDATA;
   logic [NUM_SLV-1:0]    PREADY;

   apb_master_bridge #(.NUM_SLV(NUM_SLV), .BASE_HI(BASE_HI), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA), .PENABLE(PENABLE),
      .PSEL(PSEL), .PRDATA(PRDATA), .PREADY(PREADY)
   );

   always #5 PCLK = ~PCLK;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   always @(posedge PCLK) cyc++;

   // ---------------- behavioural slave array ----------------
   logic [31:0]        slv_data [NUM_SLV];
   int                 slv_wait = 0;
   int                 acc_cnt;
   logic [NUM_SLV-1:0] noise = '0;

   initial for (int i = 0; i < NUM_SLV; i++) slv_data[i] = 32'd0;

   // Number of ACCESS cycles already spent without ready in the current transfer.
   always @(posedge PCLK or posedge PRESET) begin
      if (PRESET) acc_cnt <= 0;
      else if (PENABLE && PSEL != '0) acc_cnt <= acc_cnt + 1;
      else acc_cnt <= 0;
   end

   // Unselected slaves toggle PREADY randomly; the bridge must ignore them.
   always @(negedge PCLK) noise <= NUM_SLV'($urandom);

   always_comb begin
      PRDATA = '0;
      for (int i = 0; i < NUM_SLV; i++) PRDATA[32*i +: 32] = slv_data[i];
      PREADY = (noise & ~PSEL) | (PSEL & {NUM_SLV{acc_cnt == slv_wait}});
   end

   // ---------------- bus protocol monitor ----------------
   logic [31:0]        exp_addr = 32'd0, exp_wdata = 32'd0;
   logic               exp_write = 1'b0, exp_hit = 1'b0;
   logic [NUM_SLV-1:0] exp_sel = '0;
   int                 viol = 0;

   always @(negedge PCLK) begin
      if (!PRESET) begin
         if ((PSEL & (PSEL - 1'b1)) != '0) viol++;
         if (PENABLE && PSEL == '0) viol++;
         if (PSEL != '0 && (req_ready || !exp_hit || PSEL != exp_sel ||
             PADDR != exp_addr || PWRITE != exp_write || PWDATA != exp_wdata)) viol++;
      end
   end

   // ---------------- reference model ----------------
   function automatic void model(input logic wr, input logic [31:0] addr, input int waits,
                                 output int cyc_o, output logic [31:0] rd_o, output logic err_o,
                                 output int nsel_o);
      if (addr[31:16] != BASE_HI) begin
         cyc_o = 1; rd_o = 32'd0; err_o = 1'b1; nsel_o = 0;
      end else if (waits < TIMEOUT) begin
         cyc_o = 3 + waits; rd_o = wr ? 32'd0 : slv_data[addr[13:12]]; err_o = 1'b0;
         nsel_o = 2 + waits;
      end else begin
         cyc_o = 2 + TIMEOUT; rd_o = 32'd0; err_o = 1'b1; nsel_o = 1 + TIMEOUT;
      end
   endfunction

   // ---------------- transaction driver (observes only) ----------------
   int          ob_tacc, ob_rsp, ob_fsel, ob_nsel, ob_fen, ob_nen, ob_rdybusy;
   logic [31:0] ob_rdata, ob_rdata_after;
   logic        ob_err, ob_rdy0, ob_rdy_after;

   // Called at a point in an IDLE cycle between negedge and posedge.
   task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int waits, input bit hold);
      logic [NUM_SLV-1:0] one;
      one = 1;
      ob_rdy0 = req_ready; ob_tacc = cyc;
      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; slv_wait = waits;
      exp_addr = addr; exp_write = wr; exp_wdata = wdata;
      exp_hit = (addr[31:16] == BASE_HI); exp_sel = one << addr[13:12];
      ob_rsp = -1; ob_fsel = -1; ob_nsel = 0; ob_fen = -1; ob_nen = 0; ob_rdybusy = 0;
      ob_rdata = 32'hx; ob_err = 1'bx;
      for (int k = 1; k <= 60; k++) begin
         @(negedge PCLK);
         if (!hold) req_valid = 1'b0;
         if (PSEL != '0) begin if (ob_fsel < 0) ob_fsel = k; ob_nsel++; end
         if (PENABLE) begin if (ob_fen < 0) ob_fen = k; ob_nen++; end
         if (req_ready) ob_rdybusy++;
         if (rsp_valid) begin ob_rsp = k; ob_rdata = rsp_rdata; ob_err = rsp_err; break; end
      end
      @(negedge PCLK);
      ob_rdy_after = req_ready; ob_rdata_after = rsp_rdata;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      PRESET = 1'b1;
      repeat (2) @(negedge PCLK);
      n_checks++; if ({PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err} !== '0) begin
         n_fail++; $display("FAIL reset_values: got psel=%b pen=%b pwr=%b paddr=%h pwdata=%h rv=%b rd=%h re=%b required all 0",
                            PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err); end
      PRESET = 1'b0;
      #1;
      n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", req_ready); end
   endtask

   task automatic test_write_wait();
      int v0;
      v0 = viol;
      for (int i = 0; i < NUM_SLV; i++) slv_data[i] = $urandom;
      run_txn(1'b1, 32'h1000_1004, 32'h0000_00A5, 2, 1'b0);
      n_checks++; if (ob_rdy0 !== 1'b1) begin n_fail++; $display("FAIL wr_ready0: got %b required 1", ob_rdy0); end
      n_checks++; if (ob_rsp != 5) begin n_fail++; $display("FAIL wr_rsp_cycle: got %0d required 5", ob_rsp); end
      n_checks++; if (ob_err !== 1'b0) begin n_fail++; $display("FAIL wr_err: got %b required 0", ob_err); end
      n_checks++; if (ob_rdata !== 32'd0) begin n_fail++; $display("FAIL wr_rdata: got %h required 0", ob_rdata); end
      n_checks++; if (ob_fsel != 1 || ob_nsel != 4) begin n_fail++; $display("FAIL wr_psel_window: got first=%0d n=%0d required 1 4", ob_fsel, ob_nsel); end
      n_checks++; if (ob_fen != 2 || ob_nen != 3) begin n_fail++; $display("FAIL wr_penable_window: got first=%0d n=%0d required 2 3", ob_fen, ob_nen); end
      n_checks++; if (ob_rdybusy != 0) begin n_fail++; $display("FAIL wr_ready_busy: got %0d cycles required 0", ob_rdybusy); end
      n_checks++; if (viol != v0) begin n_fail++; $display("FAIL wr_bus_protocol: got %0d violations required 0", viol - v0); end
   endtask

   task automatic test_read_zero_wait();
      int v0;
      v0 = viol;
      for (int i = 0; i < NUM_SLV; i++) slv_data[i] = $urandom;
      slv_data[3] = 32'h1234_5678;
      run_txn(1'b0, 32'h1000_3000, 32'hDEAD_BEEF, 0, 1'b0);
      n_checks++; if (ob_rsp != 3) begin n_fail++; $display("FAIL rd_rsp_cycle: got %0d required 3", ob_rsp); end
      n_checks++; if (ob_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rdata: got %h required 12345678", ob_rdata); end
      n_checks++; if (ob_err !== 1'b0) begin n_fail++; $display("FAIL rd_err: got %b required 0", ob_err); end
      n_checks++; if (ob_rdy_after !== 1'b1) begin n_fail++; $display("FAIL rd_ready_cycle4: got %b required 1", ob_rdy_after); end
      n_checks++; if (ob_rdata_after !== 32'h1234_5678) begin n_fail++; $display("FAIL rd_rdata_hold: got %h required 12345678", ob_rdata_after); end
      n_checks++; if (viol != v0) begin n_fail++; $display("FAIL rd_bus_protocol: got %0d violations required 0", viol - v0); end
   endtask

   task automatic test_miss();
      int v0;
      v0 = viol;
      run_txn(1'b0, 32'h2000_0000, 32'd0, 0, 1'b0);
      n_checks++; if (ob_nsel != 0) begin n_fail++; $display("FAIL miss_psel: got %0d selected cycles required 0", ob_nsel); end
      n_checks++; if (ob_rsp != 1) begin n_fail++; $display("FAIL miss_rsp_cycle: got %0d required 1", ob_rsp); end
      n_checks++; if (ob_err !== 1'b1) begin n_fail++; $display("FAIL miss_err: got %b required 1", ob_err); end
      n_checks++; if (ob_rdata !== 32'd0) begin n_fail++; $display("FAIL miss_rdata: got %h required 0", ob_rdata); end
      n_checks++; if (ob_rdy_after !== 1'b1) begin n_fail++; $display("FAIL miss_ready_after: got %b required 1", ob_rdy_after); end
      n_checks++; if (viol != v0) begin n_fail++; $display("FAIL miss_bus_protocol: got %0d violations required 0", viol - v0); end
   endtask

   task automatic test_timeout();
      int v0;
      v0 = viol;
      for (int i = 0; i < NUM_SLV; i++) slv_data[i] = $urandom;
      // Ready on the last permitted ACCESS cycle still succeeds.
      run_txn(1'b0, 32'h1000_2008, 32'd0, TIMEOUT - 1, 1'b0);
      n_checks++; if (ob_rsp != TIMEOUT + 2 || ob_err !== 1'b0 || ob_rdata !== slv_data[2]) begin
         n_fail++; $display("FAIL to_edge_ok: got cyc=%0d err=%b rd=%h required %0d 0 %h", ob_rsp, ob_err, ob_rdata, TIMEOUT + 2, slv_data[2]); end
      // Slave never answers.
      run_txn(1'b0, 32'h1000_2000, 32'd0, 100000, 1'b0);
      n_checks++; if (ob_nen != TIMEOUT) begin n_fail++; $display("FAIL to_access_cycles: got %0d required %0d", ob_nen, TIMEOUT); end
      n_checks++; if (ob_err !== 1'b1 || ob_rdata !== 32'd0) begin n_fail++; $display("FAIL to_err: got err=%b rd=%h required 1 0", ob_err, ob_rdata); end
      n_checks++; if (ob_rsp != TIMEOUT + 2) begin n_fail++; $display("FAIL to_rsp_cycle: got %0d required %0d", ob_rsp, TIMEOUT + 2); end
      n_checks++; if (viol != v0) begin n_fail++; $display("FAIL to_bus_protocol: got %0d violations required 0", viol - v0); end
   endtask

   task automatic test_reset_midflight();
      int n_rv;
      logic [31:0] wd;
      exp_addr = 32'h1000_2000; exp_write = 1'b0; exp_wdata = 32'd0; exp_hit = 1'b1; exp_sel = 4'b0100;
      slv_wait = 100000;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h1000_2000; req_wdata = 32'd0;
      repeat (4) @(negedge PCLK);
      req_valid = 1'b0;
      n_checks++; if (PENABLE !== 1'b1 || PSEL !== 4'b0100) begin n_fail++; $display("FAIL rst_pre_access: got pen=%b psel=%b required 1 0100", PENABLE, PSEL); end
      PRESET = 1'b1;
      #1;
      n_checks++; if (PSEL !== '0 || PENABLE !== 1'b0) begin n_fail++; $display("FAIL rst_async_drop: got psel=%b pen=%b required 0 0", PSEL, PENABLE); end
      n_rv = 0;
      repeat (2) begin @(negedge PCLK); if (rsp_valid) n_rv++; end
      PRESET = 1'b0;
      repeat (12) begin @(negedge PCLK); if (rsp_valid) n_rv++; end
      n_checks++; if (n_rv != 0) begin n_fail++; $display("FAIL rst_no_rsp: got %0d strobes required 0", n_rv); end
      wd = $urandom;
      run_txn(1'b1, 32'h1000_2010, wd, 1, 1'b0);
      n_checks++; if (ob_rsp != 4 || ob_err !== 1'b0) begin n_fail++; $display("FAIL rst_post_write: got cyc=%0d err=%b required 4 0", ob_rsp, ob_err); end
   endtask

   task automatic test_back_to_back();
      int v0;
      int t [3];
      v0 = viol;
      for (int i = 0; i < NUM_SLV; i++) slv_data[i] = $urandom;
      for (int s = 0; s < 3; s++) begin
         run_txn(1'b0, {BASE_HI, 4'(s), 12'h00C}, 32'd0, 0, 1'b1);
         t[s] = ob_tacc;
         n_checks++; if (ob_rsp != 3 || ob_rdata !== slv_data[s] || ob_err !== 1'b0) begin
            n_fail++; $display("FAIL b2b_rsp%0d: got cyc=%0d rd=%h err=%b required 3 %h 0", s, ob_rsp, ob_rdata, ob_err, slv_data[s]); end
      end
      req_valid = 1'b0;
      n_checks++; if (t[1] - t[0] != 4 || t[2] - t[1] != 4) begin
         n_fail++; $display("FAIL b2b_spacing: got %0d %0d required 4 4", t[1] - t[0], t[2] - t[1]); end
      n_checks++; if (viol != v0) begin n_fail++; $display("FAIL b2b_bus_protocol: got %0d violations required 0", viol - v0); end
   endtask

   task automatic test_random();
      int v0, e_cyc, e_nsel, bad;
      logic [31:0] e_rd, addr, wd;
      logic e_err, wr;
      int waits;
      v0 = viol;
      for (int n = 0; n < 40; n++) begin
         for (int i = 0; i < NUM_SLV; i++) slv_data[i] = $urandom;
         wr = 1'($urandom);
         wd = $urandom;
         addr = {BASE_HI, 16'($urandom)};
         if ($urandom_range(0, 3) == 0) begin
            addr[31:16] = 16'($urandom);
            if (addr[31:16] == BASE_HI) addr[31:16] = ~BASE_HI;
         end
         waits = $urandom_range(0, TIMEOUT + 2);
         model(wr, addr, waits, e_cyc, e_rd, e_err, e_nsel);
         run_txn(wr, addr, wd, waits, 1'b0);
         bad = (ob_rsp != e_cyc) || (ob_rdata !== e_rd) || (ob_err !== e_err) ||
               (ob_nsel != e_nsel) || (ob_rdata_after !== e_rd) || (ob_rdybusy != 0);
         n_checks++; if (bad != 0) begin
            n_fail++; $display("FAIL rand%0d a=%h w=%b wt=%0d: got cyc=%0d rd=%h err=%b nsel=%0d hold=%h busy=%0d required %0d %h %b %0d %h 0",
                               n, addr, wr, waits, ob_rsp, ob_rdata, ob_err, ob_nsel, ob_rdata_after, ob_rdybusy, e_cyc, e_rd, e_err, e_nsel, e_rd); end
      end
      n_checks++; if (viol != v0) begin n_fail++; $display("FAIL rand_bus_protocol: got %0d violations required 0", viol - v0); end
   endtask

   initial begin
      test_reset();
      test_write_wait();
      test_read_zero_wait();
      test_miss();
      test_timeout();
      test_reset_midflight();
      test_back_to_back();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
